factor_game_ctrl: RTL and testbench

Game sequencer for the factorization quiz board. It sits between the switch/button inputs and the question generator and display datapath. It walks the player through ready → question → prime selection → divisibility check. It owns the hit-point (HP) counter and the remaining-value register, and it runs the divisibility check as a multi-cycle repeated-subtraction loop, so no hardware divider is needed.

---
 rtl/factor_game_ctrl.sv | 138 +++++++++++++
 tb/tb_factor_game_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/factor_game_ctrl.sv
// factor_game_ctrl: quiz sequencer with HP tracking and a repeated-subtraction divisibility check.
// Define FACTOR_TIMEOUT_EN to add a PLAY-state answer timer of TIMEOUT cycles.
module factor_game_ctrl #(
  parameter int NUM_W   = 10,
  parameter int HP_INIT = 3,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ready_i,
  input  logic             que_i,
  input  logic [2:0]       sel_i,
  input  logic             dec_i,
  input  logic             clr_i,
  input  logic             num_valid_i,
  input  logic [NUM_W-1:0] num_i,
  output logic             num_req_o,
  output logic [NUM_W-1:0] rem_o,
  output logic [1:0]       hp_o,
  output logic [2:0]       state_o,
  output logic             correct_o,
  output logic             wrong_o,
  output logic             ledr_o
);
  typedef enum logic [2:0] {IDLE, WAIT_Q, FETCH, PLAY, CHECK, CLEAR, OVER} state_t;
  state_t           state_q, state_d;
  logic [NUM_W-1:0] rem_q, rem_d, acc_q, acc_d, p_q, p_d, q_q, q_d, prime;
  logic [1:0]       hp_q, hp_d, hp_dec;
  logic             que_q, num_req_q, num_req_d, correct_q, correct_d, wrong_q, wrong_d, ledr_q;
  logic             que_rise, sel_ok, tmo;
  assign que_rise = que_i & ~que_q;
  assign sel_ok   = sel_i < 3'd6;
  assign prime    = NUM_W'(sel_i == 3'd0 ? 4'd2 : sel_i == 3'd1 ? 4'd3 : sel_i == 3'd2 ? 4'd5 :
                           sel_i == 3'd3 ? 4'd7 : sel_i == 3'd4 ? 4'd11 : 4'd13);
  assign hp_dec   = (hp_q == 2'd0) ? 2'd0 : hp_q - 2'd1;
`ifdef FACTOR_TIMEOUT_EN
  logic [31:0] tmr_q, tmr_d;
  assign tmo   = (state_q == PLAY) && (tmr_q == 32'd0);
  // Reload on every PLAY entry and on a non-fatal expiry; frozen elsewhere.
  assign tmr_d = (state_d == PLAY && (state_q != PLAY || tmo)) ? 32'(TIMEOUT - 1) :
                 (state_q == PLAY) ? tmr_q - 32'd1 : tmr_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) tmr_q <= '0;
    else tmr_q <= tmr_d;
`else
  logic unused_tmo;
  assign tmo        = 1'b0;
  assign unused_tmo = |TIMEOUT;
`endif
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    hp_d      = hp_q;
    acc_d     = acc_q;
    p_d       = p_q;
    q_d       = q_q;
    num_req_d = 1'b0;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    if (!ready_i) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_Q;
          hp_d    = 2'(HP_INIT);
        end
        WAIT_Q, CLEAR: state_d = que_rise ? FETCH : state_q;
        FETCH: if (num_valid_i) begin
          if (num_i >= NUM_W'(2)) begin
            rem_d   = num_i;
            state_d = PLAY;
          end else num_req_d = 1'b1;
        end
        PLAY: if (clr_i) state_d = WAIT_Q;
        else if (dec_i && sel_ok) begin
          state_d = CHECK;
          acc_d   = rem_q;
          p_d     = prime;
          q_d     = '0;
        end else if (tmo) begin
          wrong_d = 1'b1;
          hp_d    = hp_dec;
          state_d = (hp_dec == 2'd0) ? OVER : PLAY;
        end
        CHECK: if (clr_i) state_d = WAIT_Q;
        else if (acc_q >= p_q) begin
          acc_d = acc_q - p_q;
          q_d   = q_q + NUM_W'(1);
        end else if (acc_q == '0) begin
          rem_d     = q_q;
          correct_d = 1'b1;
          state_d   = (q_q == NUM_W'(1)) ? CLEAR : PLAY;
        end else begin
          wrong_d = 1'b1;
          hp_d    = hp_dec;
          state_d = (hp_dec == 2'd0) ? OVER : PLAY;
        end
        default: state_d = state_q;
      endcase
    end
    num_req_d = num_req_d | (state_d == FETCH && state_q != FETCH);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      hp_q      <= '0;
      acc_q     <= '0;
      p_q       <= '0;
      q_q       <= '0;
      que_q     <= 1'b0;
      num_req_q <= 1'b0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
      ledr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      hp_q      <= hp_d;
      acc_q     <= acc_d;
      p_q       <= p_d;
      q_q       <= q_d;
      que_q     <= que_i;
      num_req_q <= num_req_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
      ledr_q    <= state_d == CLEAR;
    end
  assign num_req_o = num_req_q;
  assign rem_o     = rem_q;
  assign hp_o      = hp_q;
  assign state_o   = state_q;
  assign correct_o = correct_q;
  assign wrong_o   = wrong_q;
  assign ledr_o    = ledr_q;
endmodule

// File: tb/tb_factor_game_ctrl.sv
// tb_factor_game_ctrl: directed scenario tests for factor_game_ctrl in its default build.
module tb_factor_game_ctrl;
  logic       clk_i = 1'b0, rst_ni = 1'b0, ready_i = 1'b0, que_i = 1'b0;
  logic       dec_i = 1'b0, clr_i = 1'b0, num_valid_i = 1'b0;
  logic [2:0] sel_i = 3'd0;
  logic [9:0] num_i = 10'd0;
  logic       num_req_o, correct_o, wrong_o, ledr_o;
  logic [9:0] rem_o;
  logic [1:0] hp_o;
  logic [2:0] state_o;
  int         passed = 0, total = 0;

  factor_game_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ready_i(ready_i), .que_i(que_i), .sel_i(sel_i),
    .dec_i(dec_i), .clr_i(clr_i), .num_valid_i(num_valid_i), .num_i(num_i),
    .num_req_o(num_req_o), .rem_o(rem_o), .hp_o(hp_o), .state_o(state_o),
    .correct_o(correct_o), .wrong_o(wrong_o), .ledr_o(ledr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick;
    @(negedge clk_i);
  endtask

  task automatic fetch(input logic [9:0] n);
    que_i = 1'b1; tick; que_i = 1'b0;
    num_valid_i = 1'b1; num_i = n; tick; num_valid_i = 1'b0;
  endtask

  task automatic decide(input logic [2:0] s, output int cyc);
    sel_i = s; dec_i = 1'b1; tick; dec_i = 1'b0; cyc = 0;
    while (state_o == 3'd4 && cyc < 600) begin cyc++; tick; end
  endtask

  task automatic test_reset;
    tick;
    total++; if (state_o !== 3'd0) $display("FAIL reset_state: got %0d expected 0", state_o); else passed++;
    total++; if ({rem_o, hp_o} !== 12'd0) $display("FAIL reset_rem_hp: got rem=%0d hp=%0d expected 0/0", rem_o, hp_o); else passed++;
    total++; if ({num_req_o, correct_o, wrong_o, ledr_o} !== 4'd0) $display("FAIL reset_pulses: got %b expected 0000", {num_req_o, correct_o, wrong_o, ledr_o}); else passed++;
    rst_ni = 1'b1; tick;
  endtask

  task automatic test_correct;
    int cyc;
    ready_i = 1'b1; tick;
    total++; if (state_o !== 3'd1 || hp_o !== 2'd3) $display("FAIL arm: got state=%0d hp=%0d expected 1/3", state_o, hp_o); else passed++;
    que_i = 1'b1; tick; que_i = 1'b0;
    total++; if (state_o !== 3'd2 || num_req_o !== 1'b1) $display("FAIL fetch_req: got state=%0d req=%b expected 2/1", state_o, num_req_o); else passed++;
    num_valid_i = 1'b1; num_i = 10'd12; tick; num_valid_i = 1'b0;
    total++; if (state_o !== 3'd3 || rem_o !== 10'd12 || num_req_o !== 1'b0) $display("FAIL play_12: got state=%0d rem=%0d req=%b expected 3/12/0", state_o, rem_o, num_req_o); else passed++;
    decide(3'd0, cyc);
    total++; if (cyc !== 7) $display("FAIL check_len_12_2: got %0d cycles expected 7", cyc); else passed++;
    total++; if (state_o !== 3'd3 || rem_o !== 10'd6 || correct_o !== 1'b1 || wrong_o !== 1'b0) $display("FAIL correct_12_2: got state=%0d rem=%0d c=%b w=%b expected 3/6/1/0", state_o, rem_o, correct_o, wrong_o); else passed++;
    tick;
    total++; if (correct_o !== 1'b0) $display("FAIL correct_pulse_width: got %b expected 0", correct_o); else passed++;
    decide(3'd0, cyc);
    total++; if (rem_o !== 10'd3 || correct_o !== 1'b1 || cyc !== 4) $display("FAIL correct_6_2: got rem=%0d c=%b cyc=%0d expected 3/1/4", rem_o, correct_o, cyc); else passed++;
    decide(3'd1, cyc);
    total++; if (rem_o !== 10'd1 || state_o !== 3'd5 || ledr_o !== 1'b1 || correct_o !== 1'b1) $display("FAIL clear_3_3: got rem=%0d state=%0d ledr=%b c=%b expected 1/5/1/1", rem_o, state_o, ledr_o, correct_o); else passed++;
  endtask

  task automatic test_wrong;
    int cyc;
    fetch(10'd15);
    total++; if (state_o !== 3'd3 || rem_o !== 10'd15 || ledr_o !== 1'b0 || hp_o !== 2'd3) $display("FAIL next_question: got state=%0d rem=%0d ledr=%b hp=%0d expected 3/15/0/3", state_o, rem_o, ledr_o, hp_o); else passed++;
    decide(3'd0, cyc);
    total++; if (wrong_o !== 1'b1 || correct_o !== 1'b0 || hp_o !== 2'd2 || rem_o !== 10'd15 || state_o !== 3'd3 || cyc !== 8) $display("FAIL wrong_15_2: got w=%b c=%b hp=%0d rem=%0d state=%0d cyc=%0d expected 1/0/2/15/3/8", wrong_o, correct_o, hp_o, rem_o, state_o, cyc); else passed++;
    decide(3'd0, cyc);
    total++; if (hp_o !== 2'd1 || state_o !== 3'd3) $display("FAIL wrong_second: got hp=%0d state=%0d expected 1/3", hp_o, state_o); else passed++;
    decide(3'd3, cyc);
    total++; if (hp_o !== 2'd0 || state_o !== 3'd6 || wrong_o !== 1'b1) $display("FAIL game_over: got hp=%0d state=%0d w=%b expected 0/6/1", hp_o, state_o, wrong_o); else passed++;
    que_i = 1'b1; tick; que_i = 1'b0; tick;
    total++; if (state_o !== 3'd6 || wrong_o !== 1'b0) $display("FAIL over_hold: got state=%0d w=%b expected 6/0", state_o, wrong_o); else passed++;
    ready_i = 1'b0; tick;
    total++; if (state_o !== 3'd0 || rem_o !== 10'd0) $display("FAIL ready_low: got state=%0d rem=%0d expected 0/0", state_o, rem_o); else passed++;
  endtask

  task automatic test_que_level;
    que_i = 1'b1; tick;
    ready_i = 1'b1; tick; tick;
    total++; if (state_o !== 3'd1 || hp_o !== 2'd3) $display("FAIL que_level_no_fire: got state=%0d hp=%0d expected 1/3", state_o, hp_o); else passed++;
    que_i = 1'b0; tick;
  endtask

  task automatic test_refetch;
    que_i = 1'b1; tick; que_i = 1'b0;
    num_valid_i = 1'b1; num_i = 10'd1; tick; num_valid_i = 1'b0;
    total++; if (state_o !== 3'd2 || num_req_o !== 1'b1) $display("FAIL refetch_req: got state=%0d req=%b expected 2/1", state_o, num_req_o); else passed++;
    tick;
    total++; if (state_o !== 3'd2 || num_req_o !== 1'b0) $display("FAIL refetch_wait: got state=%0d req=%b expected 2/0", state_o, num_req_o); else passed++;
    num_valid_i = 1'b1; num_i = 10'd14; tick; num_valid_i = 1'b0;
    total++; if (state_o !== 3'd3 || rem_o !== 10'd14) $display("FAIL refetch_play: got state=%0d rem=%0d expected 3/14", state_o, rem_o); else passed++;
  endtask

  task automatic test_clr_dec;
    sel_i = 3'd7; dec_i = 1'b1; tick; dec_i = 1'b0;
    total++; if (state_o !== 3'd3) $display("FAIL bad_sel_ignored: got state=%0d expected 3", state_o); else passed++;
    sel_i = 3'd0; dec_i = 1'b1; clr_i = 1'b1; tick; dec_i = 1'b0; clr_i = 1'b0;
    total++; if (state_o !== 3'd1 || hp_o !== 2'd3 || rem_o !== 10'd14) $display("FAIL clr_wins: got state=%0d hp=%0d rem=%0d expected 1/3/14", state_o, hp_o, rem_o); else passed++;
  endtask

  task automatic test_rst_check;
    fetch(10'd1000);
    sel_i = 3'd0; dec_i = 1'b1; tick; dec_i = 1'b0; tick; tick;
    total++; if (state_o !== 3'd4) $display("FAIL in_check_1000: got state=%0d expected 4", state_o); else passed++;
    @(posedge clk_i); #2 rst_ni = 1'b0; #1;
    total++; if (state_o !== 3'd0 || hp_o !== 2'd0 || rem_o !== 10'd0 || correct_o !== 1'b0 || wrong_o !== 1'b0) $display("FAIL async_rst: got state=%0d hp=%0d rem=%0d c=%b w=%b expected 0/0/0/0/0", state_o, hp_o, rem_o, correct_o, wrong_o); else passed++;
    tick; tick;
    total++; if ({correct_o, wrong_o, num_req_o} !== 3'd0) $display("FAIL rst_no_pulse: got %b expected 000", {correct_o, wrong_o, num_req_o}); else passed++;
  endtask

  initial begin
    test_reset;
    test_correct;
    test_wrong;
    test_que_level;
    test_refetch;
    test_clr_dec;
    test_rst_check;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
